// File: rtl/pkt_dma_pkg.sv
// -----------------------------------------------------------------------------
// pkt_dma_pkg
// Shared definitions for the packet DMA writer: FSM state encoding, the
// position of the length field inside the length flit, the full byte-enable
// constant used for every memory write, and a small state-decode helper.
//
// Optional feature macro: PKT_DMA_CHECKSUM_EN
//   When defined, the CKSUM state exists and the writer appends a payload
//   checksum word after the payload. When undefined, the state is absent.
// -----------------------------------------------------------------------------
package pkt_dma_pkg;

  // Length field location inside the second (length) flit of a packet.
  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;

  // Every memory write stores a whole 32-bit word.
  localparam logic [3:0] BE_FULL = 4'b1111;

  // Receive FSM states. CKSUM only exists when the checksum feature is built.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    PAYLOAD,
`ifdef PKT_DMA_CHECKSUM_EN
    CKSUM,
`endif
    DONE
  } state_t;

  // States in which a packet is in flight.
  function automatic logic isBusyState(input state_t s);
    logic busy;
    busy = 1'b0;
    case (s)
      HDR, LEN, PAYLOAD: busy = 1'b1;
`ifdef PKT_DMA_CHECKSUM_EN
      CKSUM:             busy = 1'b1;
`endif
      default:           busy = 1'b0;
    endcase
    return busy;
  endfunction

  // States in which the writer offers to take flits from the router.
  function automatic logic isFlitState(input state_t s);
    return (s == HDR) || (s == LEN) || (s == PAYLOAD);
  endfunction

endpackage

// File: rtl/pkt_dma_writer.sv
// -----------------------------------------------------------------------------
// pkt_dma_writer
// Receives a packet from a router as a stream of 32-bit flits and writes it
// into a word-addressed RAM starting at a programmable byte address.
// Packet format: header flit, length flit (payload word count in bits
// [15:0]), then that many payload flits. Every accepted header/length/payload
// flit is written in the same cycle it is accepted (zero write latency).
// Payload words beyond MAX_WORDS are swallowed without being written and flag
// an overflow. The write address wraps modulo SIZE.
//
// Optional feature macro: PKT_DMA_CHECKSUM_EN
//   When defined, a 32-bit wraparound sum of the written payload words is
//   kept and written as one extra word right after the payload.
//
// Parameters
//   MEMORY_BUS_WIDTH  flit / memory data width in bits (32)
//   SIZE              target memory size in bytes; address width is clog2(SIZE)
//   MAX_WORDS         payload words written per packet before overflow
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   flit_in         incoming flit from the router
//   flit_valid_in   flit_in is valid
//   flit_ready_out  writer can accept a flit this cycle
//   base_addr_in    receive buffer byte address, sampled with start_in
//   start_in        one-cycle pulse arming reception (ignored while busy)
//   busy_out        a packet is being received
//   done_out        a packet has completed
//   overflow_out    payload exceeded MAX_WORDS
//   checksum_out    payload checksum (0 when the feature is not built)
//   mem_enable_out  RAM write strobe
//   mem_wb_out      RAM byte enables (0 whenever no write)
//   mem_addr_out    RAM byte address
//   mem_data_out    RAM write data
// -----------------------------------------------------------------------------
module pkt_dma_writer
  import pkt_dma_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int SIZE             = 65536,
  parameter int MAX_WORDS        = 256,
  localparam int ADDR_W          = $clog2(SIZE)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MEMORY_BUS_WIDTH-1:0] flit_in,
  input  logic                        flit_valid_in,
  output logic                        flit_ready_out,
  input  logic [ADDR_W-1:0]           base_addr_in,
  input  logic                        start_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        overflow_out,
  output logic [31:0]                 checksum_out,
  output logic                        mem_enable_out,
  output logic [3:0]                  mem_wb_out,
  output logic [ADDR_W-1:0]           mem_addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  // Where the FSM goes once the payload has been consumed.
`ifdef PKT_DMA_CHECKSUM_EN
  localparam state_t AFTER_DATA = CKSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_waddr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_wordCnt;
  logic               r_overflow;
`ifdef PKT_DMA_CHECKSUM_EN
  logic [31:0]        r_checksum;
`endif

  logic               w_ready;
  logic               w_accept;
  logic               w_capOk;
  logic               w_lastPayload;
  logic [LEN_W-1:0]   w_lenField;
  logic               w_arm;

  // Handshake and payload bookkeeping decodes.
  assign w_ready       = isFlitState(r_state);
  assign w_accept      = w_ready && flit_valid_in;
  assign w_lenField    = flit_in[LEN_LSB +: LEN_W];
  // Payload words with index below MAX_WORDS are stored; later ones are dropped.
  assign w_capOk       = 32'(r_wordCnt) < 32'(MAX_WORDS);
  assign w_lastPayload = (r_wordCnt == (r_len - LEN_W'(1)));
  // start_in only matters when no packet is in flight.
  assign w_arm         = start_in && ((r_state == IDLE) || (r_state == DONE));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and memory write port decode. Writes follow the accepted
  // handshake combinationally, so the RAM sees each flit in its accept cycle.
  always_comb begin
    w_nextState    = r_state;
    mem_enable_out = 1'b0;
    mem_wb_out     = '0;
    mem_addr_out   = r_waddr;
    mem_data_out   = flit_in;

    case (r_state)
      IDLE: begin
        if (start_in) w_nextState = HDR;
      end

      HDR: begin
        if (w_accept) begin
          mem_enable_out = 1'b1;
          mem_wb_out     = BE_FULL;
          w_nextState    = LEN;
        end
      end

      LEN: begin
        if (w_accept) begin
          mem_enable_out = 1'b1;
          mem_wb_out     = BE_FULL;
          w_nextState    = (w_lenField != '0) ? PAYLOAD : AFTER_DATA;
        end
      end

      PAYLOAD: begin
        if (w_accept) begin
          if (w_capOk) begin
            mem_enable_out = 1'b1;
            mem_wb_out     = BE_FULL;
          end
          if (w_lastPayload) w_nextState = AFTER_DATA;
        end
      end

`ifdef PKT_DMA_CHECKSUM_EN
      // One cycle with no flit intake: store the running sum after the payload.
      CKSUM: begin
        mem_enable_out = 1'b1;
        mem_wb_out     = BE_FULL;
        mem_data_out   = MEMORY_BUS_WIDTH'(r_checksum);
        w_nextState    = DONE;
      end
`endif

      DONE: begin
        if (start_in) w_nextState = HDR;
      end

      default: w_nextState = IDLE;
    endcase
  end

  // Write address: loaded on arm, advanced only by flit writes that actually
  // reach memory, so dropped overflow words leave it frozen. Wraps at SIZE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_waddr <= '0;
    end else if (w_arm) begin
      r_waddr <= base_addr_in;
    end else if (w_accept && mem_enable_out) begin
      r_waddr <= r_waddr + ADDR_STEP;
    end
  end

  // Length capture and payload word counter. The counter restarts when the
  // length flit is taken and counts every accepted payload flit, written or not.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len     <= '0;
      r_wordCnt <= '0;
    end else if (w_arm) begin
      r_len     <= '0;
      r_wordCnt <= '0;
    end else if (w_accept && (r_state == LEN)) begin
      r_len     <= w_lenField;
      r_wordCnt <= '0;
    end else if (w_accept && (r_state == PAYLOAD)) begin
      r_wordCnt <= r_wordCnt + LEN_W'(1);
    end
  end

  // Overflow flag: set by the first dropped payload word, cleared on re-arm.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_arm) begin
      r_overflow <= 1'b0;
    end else if (w_accept && (r_state == PAYLOAD) && !w_capOk) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef PKT_DMA_CHECKSUM_EN
  // Running wraparound sum of the payload words that were stored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_arm) begin
      r_checksum <= '0;
    end else if (w_accept && (r_state == PAYLOAD) && w_capOk) begin
      r_checksum <= r_checksum + 32'(flit_in);
    end
  end

  assign checksum_out = r_checksum;
`else
  assign checksum_out = '0;
`endif

  // Status outputs decode straight from the state so reset clears them at once.
  assign flit_ready_out = w_ready;
  assign busy_out       = isBusyState(r_state);
  assign done_out       = (r_state == DONE);
  assign overflow_out   = r_overflow;

endmodule

// File: tb/tb_pkt_dma_writer.sv
// -----------------------------------------------------------------------------
// tb_pkt_dma_writer
// Randomized bench for pkt_dma_writer. A driver issues packets and pushes the
// memory writes each packet should cause into a queue; a monitor pops and
// compares every write the DUT presents. Expected writes come from the packet
// format rules: header at base, length at base+4, payload words at base+8+4k
// for the first MAX_WORDS words, optional checksum word next, all modulo SIZE.
// -----------------------------------------------------------------------------
module tb_pkt_dma_writer;

  localparam int SIZE = 65536;
  localparam int MAXW = 4;
  localparam int AW   = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   flit_in;
  logic          flit_valid_in;
  logic          flit_ready_out;
  logic [AW-1:0] base_addr_in;
  logic          start_in;
  logic          busy_out;
  logic          done_out;
  logic          overflow_out;
  logic [31:0]   checksum_out;
  logic          mem_enable_out;
  logic [3:0]    mem_wb_out;
  logic [AW-1:0] mem_addr_out;
  logic [31:0]   mem_data_out;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clock = ~clock;

  pkt_dma_writer #(
    .MEMORY_BUS_WIDTH(32),
    .SIZE(SIZE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flit_in(flit_in),
    .flit_valid_in(flit_valid_in),
    .flit_ready_out(flit_ready_out),
    .base_addr_in(base_addr_in),
    .start_in(start_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .overflow_out(overflow_out),
    .checksum_out(checksum_out),
    .mem_enable_out(mem_enable_out),
    .mem_wb_out(mem_wb_out),
    .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out)
  );

  // Single compare point: every check funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte address of the k-th word of a packet buffer, wrapping at SIZE.
  function automatic logic [AW-1:0] addrOf(input logic [AW-1:0] base, input int k);
    return AW'((int'(base) + 4 * k) % SIZE);
  endfunction

  // Monitor: compares each presented write against the oldest expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_enable_out) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr_out, mem_data_out);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("write_addr", 32'(mem_addr_out), 32'(e.addr));
          checkOutput("write_data", mem_data_out, e.data);
          checkOutput("write_wb", 32'(mem_wb_out), 32'h0000_000F);
        end
      end else begin
        checkOutput("idle_wb", 32'(mem_wb_out), 32'h0);
      end
    end
  end

  // Called at posedge+1: pulse start_in for one cycle with the given base.
  task automatic startPacket(input logic [AW-1:0] base);
    base_addr_in = base;
    start_in     = 1'b1;
    @(posedge clock); #1;
    start_in     = 1'b0;
    base_addr_in = AW'($urandom);
  endtask

  // Presents one flit until accepted, optionally preceded by idle cycles with
  // junk data and stray start pulses (both must be ignored by the DUT).
  task automatic applyStimulus(input logic [31:0] data, input bit gaps);
    bit acc;
    int n;
    acc = 1'b0;
    if (gaps) begin
      n = int'($urandom_range(1, 2));
      for (int g = 0; g < n; g++) begin
        flit_valid_in = 1'b0;
        flit_in       = $urandom;
        start_in      = ($urandom_range(0, 2) == 0);
        base_addr_in  = AW'($urandom);
        @(posedge clock); #1;
      end
      start_in = 1'b0;
    end
    flit_in       = data;
    flit_valid_in = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clock);
      acc = flit_ready_out;
      @(posedge clock); #1;
    end
    flit_valid_in = 1'b0;
    flit_in       = $urandom;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: flit 0x%0h not accepted within 20 cycles", data);
    end
  endtask

  // Runs one packet (words[0]=header, words[1]=length flit, then payload) and
  // checks the end-of-packet status against the packet rules.
  task automatic runPacket(input logic [AW-1:0] base, input logic [31:0] words[$], input bit gaps);
    int          len;
    int          nw;
    int          k;
    logic [31:0] sum;
    logic [31:0] lf;
    lf  = words[1];
    len = int'(lf[15:0]);
    nw  = (len < MAXW) ? len : MAXW;
    k   = 0;
    sum = '0;
    startPacket(base);
    checkOutput("busy_after_start", 32'(busy_out), 32'h1);
    checkOutput("done_cleared", 32'(done_out), 32'h0);
    checkOutput("overflow_cleared", 32'(overflow_out), 32'h0);
    for (int i = 0; i < 2 + len; i++) begin
      if (i < 2 + nw) begin
        expQ.push_back({addrOf(base, k), words[i]});
        k++;
        if (i >= 2) sum += words[i];
      end
      applyStimulus(words[i], gaps);
    end
`ifdef PKT_DMA_CHECKSUM_EN
    expQ.push_back({addrOf(base, k), sum});
`endif
    for (int c = 0; c < 20 && !done_out; c++) begin
      @(posedge clock); #1;
    end
    checkOutput("done_out", 32'(done_out), 32'h1);
    checkOutput("busy_at_done", 32'(busy_out), 32'h0);
    checkOutput("ready_at_done", 32'(flit_ready_out), 32'h0);
    checkOutput("overflow_out", 32'(overflow_out), (len > MAXW) ? 32'h1 : 32'h0);
`ifdef PKT_DMA_CHECKSUM_EN
    checkOutput("checksum_out", checksum_out, sum);
`else
    checkOutput("checksum_out", checksum_out, 32'h0);
`endif
    @(posedge clock); #1;
    checkOutput("writes_drained", 32'(expQ.size()), 32'h0);
  endtask

  // Abandons a packet after its 2nd payload word by asserting reset mid-cycle.
  task automatic resetMidPacket();
    logic [31:0] w;
    logic [AW-1:0] base;
    base = 16'h0400;
    startPacket(base);
    for (int i = 0; i < 4; i++) begin
      w = (i == 1) ? 32'h0000_0005 : $urandom;
      expQ.push_back({addrOf(base, i), w});
      applyStimulus(w, 1'b0);
    end
    flit_in       = $urandom;
    flit_valid_in = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_mem_enable", 32'(mem_enable_out), 32'h0);
    checkOutput("rst_wb", 32'(mem_wb_out), 32'h0);
    checkOutput("rst_ready", 32'(flit_ready_out), 32'h0);
    checkOutput("rst_busy", 32'(busy_out), 32'h0);
    checkOutput("rst_done", 32'(done_out), 32'h0);
    checkOutput("rst_overflow", 32'(overflow_out), 32'h0);
    checkOutput("rst_checksum", checksum_out, 32'h0);
    checkOutput("rst_no_pending", 32'(expQ.size()), 32'h0);
    flit_valid_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("post_rst_ready", 32'(flit_ready_out), 32'h0);
    checkOutput("post_rst_busy", 32'(busy_out), 32'h0);
  endtask

  // Overall time bound so a stuck DUT cannot hang the run.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pkt[$];
    logic [31:0] lf;
    logic [AW-1:0] base;
    int len;

    reset         = 1'b0;
    flit_in       = '0;
    flit_valid_in = 1'b0;
    base_addr_in  = '0;
    start_in      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_ready", 32'(flit_ready_out), 32'h0);
    checkOutput("reset_mem_enable", 32'(mem_enable_out), 32'h0);
    checkOutput("reset_busy", 32'(busy_out), 32'h0);
    checkOutput("reset_done", 32'(done_out), 32'h0);
    checkOutput("reset_overflow", 32'(overflow_out), 32'h0);
    checkOutput("reset_checksum", checksum_out, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("idle_ready", 32'(flit_ready_out), 32'h0);

    $display("[TB] directed: basic packet, stalled packet, empty packet");
    pkt = '{32'h0000_0102, 32'h0000_0002, 32'h0000_000A, 32'h0000_000B};
    runPacket(16'h0100, pkt, 1'b0);
    runPacket(16'h0100, pkt, 1'b1);
    pkt = '{32'hDEAD_BEEF, 32'hABCD_0000};
    runPacket(16'h0200, pkt, 1'b0);

    $display("[TB] directed: overflow and address wrap");
    pkt = '{32'h1111_1111, 32'h0000_0006, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    runPacket(16'h0300, pkt, 1'b1);
    pkt = '{32'h0000_0AAA, 32'h0000_0001, 32'h0000_0BBB};
    runPacket(16'hFFFC, pkt, 1'b0);

    $display("[TB] directed: reset mid-packet");
    resetMidPacket();

    $display("[TB] randomized packets");
    for (int p = 0; p < 30; p++) begin
      len = int'($urandom_range(0, 7));
      base = AW'($urandom) & 16'hFFFC;
      if ($urandom_range(0, 3) == 0) base = 16'hFFF0 | (AW'($urandom_range(0, 3)) << 2);
      lf = $urandom;
      lf[15:0] = 16'(len);
      pkt = '{};
      pkt.push_back($urandom);
      pkt.push_back(lf);
      for (int i = 0; i < len; i++) pkt.push_back($urandom);
      runPacket(base, pkt, ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(posedge clock);
    #1;
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_dma_writer.md
PKT_DMA_WRITER -- requirements
Module: pkt_dma_writer

Interface
REQ-001 SHALL have parameter MEMORY_BUS_WIDTH, default 32: flit and memory data width in bits.
REQ-002 SHALL have parameter SIZE, default 65536: target memory size in bytes; ADDR_W = $clog2(SIZE).
REQ-003 SHALL have parameter MAX_WORDS, default 256: payload word cap per packet.
REQ-004 SHALL have port clock, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flit_in, input, 32: incoming flit from router.
REQ-007 SHALL have port flit_valid_in, input, 1: flit_in valid.
REQ-008 SHALL have port flit_ready_out, output, 1: flit accepted when valid and ready are both high.
REQ-009 SHALL have port base_addr_in, input, ADDR_W: byte address of the receive buffer, sampled on start_in.
REQ-010 SHALL have port start_in, input, 1: one-cycle pulse that arms reception.
REQ-011 SHALL have ports busy_out, done_out and overflow_out, outputs, 1 each: status.
REQ-012 SHALL have port checksum_out, output, 32: payload checksum.
REQ-013 SHALL have ports mem_enable_out (1), mem_wb_out (4), mem_addr_out (ADDR_W) and mem_data_out (32), outputs: write port to single_port_ram.

Function
REQ-014 SHALL implement states IDLE, HDR, LEN, PAYLOAD, CKSUM and DONE.
REQ-015 IDLE: flit_ready_out=0; start_in latches base_addr_in into waddr and moves to HDR.
REQ-016 HDR, LEN, PAYLOAD: flit_ready_out=1; each accepted flit is written in the same cycle (mem_enable_out=1, mem_wb_out=4'b1111, mem_addr_out=waddr, mem_data_out=flit_in), then waddr += 4.
REQ-017 Writes SHALL be combinational from the accepted handshake; write latency is zero cycles; at most one write per cycle.
REQ-018 HDR -> LEN on accept; LEN captures len = flit_in[15:0], then goes to PAYLOAD if len != 0, else to CKSUM/DONE.
REQ-019 PAYLOAD: a word counter counts accepted flits; after the len-th flit, go to CKSUM (if compiled in) or DONE.
REQ-020 Payload flits beyond MAX_WORDS SHALL be accepted but not written (mem_enable_out=0), waddr frozen, and overflow_out set to 1.
REQ-021 waddr SHALL wrap modulo SIZE (ADDR_W-bit truncation).
REQ-022 With mem_enable_out=0, mem_wb_out SHALL be 0; mem_addr_out and mem_data_out are don't-care.
REQ-023 DONE: done_out=1 and busy_out=0; start_in re-arms directly (moves to HDR, clears done_out, overflow_out and checksum).
REQ-024 busy_out SHALL be 1 in HDR, LEN, PAYLOAD and CKSUM.
REQ-025 start_in SHALL be ignored while busy_out=1.
REQ-026 flit_valid_in low SHALL stall any state without side effects.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, waddr=0, counters=0, and all outputs 0, including flit_ready_out and mem_enable_out.
REQ-028 Reset mid-packet SHALL abandon the packet; no further writes after reset asserts.

Configuration
REQ-029 With PKT_DMA_CHECKSUM_EN defined: checksum = 32-bit wraparound sum of written payload words; CKSUM spends one cycle writing it at waddr (flit_ready_out=0), then goes to DONE; checksum_out holds the value.
REQ-030 Without PKT_DMA_CHECKSUM_EN: CKSUM state and adder SHALL be absent; checksum_out is tied to 0.

Structure
REQ-031 Package pkt_dma_pkg SHALL hold the state enum, the header/length field positions (LEN_LSB=0, LEN_W=16), and the full byte-enable constant 4'b1111.
REQ-032 No sub-module; the memory port SHALL connect to the existing interface_memory-based RAM.

Verification
REQ-033 base=0x100, start, flits 0x00000102, 0x2, 0xA, 0xB -> writes at 0x100/0x104/0x108/0x10C; done_out=1; checksum_out=0x15 and 0x15 written at 0x110 when enabled.
REQ-034 Same packet with flit_valid_in toggled every other cycle -> identical write sequence, no duplicate writes.
REQ-035 len=0 -> two writes (header, length), then DONE; checksum 0 written at base+8 when enabled.
REQ-036 MAX_WORDS=2, len=4 -> only 2 payload writes, 4 flits accepted, overflow_out=1, done_out=1.
REQ-037 base=SIZE-4, len=1 -> header at SIZE-4, length at 0x0, payload at 0x4 (wrap).
REQ-038 reset asserted after the 2nd payload flit -> mem_enable_out=0 immediately, state IDLE, flit_ready_out=0, all status 0.
